// File: rtl/stream_arb_if.sv
// Handshake/bus bundle between the stream arbiter, the core result
// buffers and the DMA write side.
interface stream_arb_if #(
  parameter int N_CORE = 4,
  parameter int AW     = 8,
  parameter int IW     = 2
);
  logic [N_CORE-1:0] fin_req;
  logic [AW-1:0]     burst_len;
  logic              dst_ready;
  logic              rd_v;
  logic [N_CORE-1:0] rd_sel;
  logic [AW-1:0]     rd_addr;
  logic              dst_valid;
  logic              dst_last;
  logic [IW-1:0]     dst_id;
  logic [N_CORE-1:0] done;
  logic              busy;

  modport master (
    input  fin_req, burst_len, dst_ready,
    output rd_v, rd_sel, rd_addr, dst_valid, dst_last, dst_id, done, busy
  );

  modport slave (
    output fin_req, burst_len, dst_ready,
    input  rd_v, rd_sel, rd_addr, dst_valid, dst_last, dst_id, done, busy
  );
endinterface

// File: rtl/stream_arb.sv
// Round-robin scheduler sharing one output stream between N_CORE result
// buffers. Finish pulses are latched, one core is granted at a time, its
// buffer is read sequentially, and the registered stream beat follows each
// read by one cycle. dst_ready low freezes everything but request capture.
module stream_arb #(
  parameter int N_CORE = 4,
  parameter int AW     = 8,
  parameter int IW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  stream_arb_if.master  bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nxt;
  logic [N_CORE-1:0] pend, pend_nxt;
  logic [N_CORE-1:0] rd_sel, rd_sel_nxt;
  logic [N_CORE-1:0] grant;
  logic [AW-1:0]     rd_addr, rd_addr_nxt;
  logic [AW-1:0]     len, len_nxt;
  logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]     win_idx, cand, sel_idx;
  logic              win_found;
  logic              at_end;
  logic              rd_v;
  logic              dst_valid, dst_last;
  logic [IW-1:0]     dst_id;
  logic [N_CORE-1:0] done_w;

  assign at_end = (rd_addr == len);
  assign rd_v   = (state == STREAM) && bus.dst_ready;

  // Round-robin search: first pending core after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_CORE; i++) begin
      cand = IW'((32'(rr_ptr) + i) % N_CORE);
      if (!win_found && pend[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // One-hot grant to binary index, used to tag the outgoing beat.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < N_CORE; i++) begin
      if (rd_sel[i]) sel_idx = IW'(i);
    end
  end

  // FSM next state: arbitrate in IDLE, walk the buffer in STREAM.
  always_comb begin
    state_nxt   = state;
    rd_sel_nxt  = rd_sel;
    rd_addr_nxt = rd_addr;
    len_nxt     = len;
    rr_ptr_nxt  = rr_ptr;
    grant       = '0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          grant[win_idx] = 1'b1;
          rd_sel_nxt     = '0;
          rd_sel_nxt[win_idx] = 1'b1;
          rr_ptr_nxt     = win_idx;
          len_nxt        = bus.burst_len;
          rd_addr_nxt    = '0;
          state_nxt      = STREAM;
        end
      end
      STREAM: begin
        if (bus.dst_ready) begin
          if (at_end) begin
            state_nxt   = IDLE;
            rd_sel_nxt  = '0;
            rd_addr_nxt = '0;
          end else begin
            rd_addr_nxt = rd_addr + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new finish pulse wins over the clear caused by a same-cycle grant.
  always_comb begin
    pend_nxt = (pend & ~grant) | bus.fin_req;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= '0;
      rd_sel  <= '0;
      rd_addr <= '0;
      len     <= '0;
      rr_ptr  <= IW'(N_CORE - 1);
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      rd_sel  <= rd_sel_nxt;
      rd_addr <= rd_addr_nxt;
      len     <= len_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // Output beat registers advance only while downstream accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_valid <= 1'b0;
      dst_last  <= 1'b0;
      dst_id    <= '0;
    end else if (bus.dst_ready) begin
      dst_valid <= rd_v;
      dst_last  <= rd_v && at_end;
      dst_id    <= sel_idx;
    end
  end

  // Completion pulse for the core whose last beat is being accepted.
  always_comb begin
    done_w = '0;
    if (dst_valid && dst_last && bus.dst_ready) done_w[dst_id] = 1'b1;
  end

  assign bus.rd_v      = rd_v;
  assign bus.rd_sel    = rd_sel;
  assign bus.rd_addr   = rd_addr;
  assign bus.dst_valid = dst_valid;
  assign bus.dst_last  = dst_last;
  assign bus.dst_id    = dst_id;
  assign bus.done      = done_w;
  assign bus.busy      = (state != IDLE) || dst_valid;

endmodule
